// File: rtl/brc_resolve_unit.sv
// brc_resolve_unit: resolves EX-stage branches, sequences mispredict flush and hands the corrected PC to fetch.
// Optional BRC_STATS_EN adds stat_branches / stat_mispredicts counters.
module brc_resolve_unit #(
   parameter int FLUSH_CYCLES = 2,
   parameter int XLEN         = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            br_valid,
   input  logic [2:0]      br_funct3,
   input  logic            A_eq_B,
   input  logic            A_lt_B,
   input  logic            A_lt_B_s,
   input  logic            br_pred_taken,
   input  logic [XLEN-1:0] br_pc,
   input  logic [XLEN-1:0] br_target,
   input  logic            redirect_ready,
   output logic            br_taken,
   output logic            flush,
   output logic            busy,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            br_illegal
`ifdef BRC_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);
   typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
   state_t          state_q;
   logic [2:0]      cnt_q;
   logic            br_taken_q, br_illegal_q, flush_q, busy_q, rv_q;
   logic [XLEN-1:0] rpc_q;
   logic            legal, cmp, taken, accept, mispredict;
   logic [XLEN-1:0] correct_pc;
   // funct3[0] inverts the base comparison (BNE/BGE/BGEU)
   always_comb begin
      legal      = br_funct3[2:1] != 2'b01;
      cmp        = br_funct3[2:1] == 2'b00 ? A_eq_B :
                   br_funct3[2:1] == 2'b10 ? A_lt_B_s :
                   br_funct3[2:1] == 2'b11 ? A_lt_B : 1'b0;
      taken      = legal & (cmp ^ br_funct3[0]);
      accept     = br_valid & (state_q == IDLE);
      mispredict = legal & (taken ^ br_pred_taken);
      correct_pc = taken ? br_target : br_pc + XLEN'(4);
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         br_taken_q   <= 1'b0;
         br_illegal_q <= 1'b0;
         flush_q      <= 1'b0;
         busy_q       <= 1'b0;
         rv_q         <= 1'b0;
         rpc_q        <= '0;
      end else begin
         br_taken_q   <= accept & taken;
         br_illegal_q <= accept & ~legal;
         case (state_q)
            IDLE: if (accept & mispredict) begin
               rpc_q  <= correct_pc;
               busy_q <= 1'b1;
               if (FLUSH_CYCLES == 0) begin
                  state_q <= REDIRECT;
                  rv_q    <= 1'b1;
               end else begin
                  state_q <= FLUSH;
                  cnt_q   <= 3'(FLUSH_CYCLES);
                  flush_q <= 1'b1;
               end
            end
            FLUSH: if (cnt_q == 3'd1) begin
               state_q <= REDIRECT;
               flush_q <= 1'b0;
               rv_q    <= 1'b1;
            end else begin
               cnt_q <= cnt_q - 3'd1;
            end
            REDIRECT: if (redirect_ready) begin
               state_q <= IDLE;
               rv_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign br_taken       = br_taken_q;
   assign br_illegal     = br_illegal_q;
   assign flush          = flush_q;
   assign busy           = busy_q;
   assign redirect_valid = rv_q;
   assign redirect_pc    = rpc_q;
`ifdef BRC_STATS_EN
   logic [31:0] nbr_q, nmis_q;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         nbr_q  <= '0;
         nmis_q <= '0;
      end else begin
         nbr_q  <= nbr_q + 32'(accept & legal);
         nmis_q <= nmis_q + 32'(accept & mispredict);
      end
   end
   assign stat_branches    = nbr_q;
   assign stat_mispredicts = nmis_q;
`endif
endmodule
